rx_sync_ctrl: RTL and testbench

//   Receive-side lane synchronisation controller behind the serial-to-parallel

---
 rtl/rx_sync_ctrl.sv | 144 ++++++++++++++
 tb/tb_rx_sync_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_sync_ctrl.sv
// Lane sync controller: hunts for COM symbols, locks after LOCK_COUNT in a row, forwards data while locked.
// Latency: 1 clk_4f from byte_in/byte_valid to data_out/valid_out; all outputs registered.
// Backpressure: none; byte_valid=0 cycles are idle and leave every counter and state untouched.
module rx_sync_ctrl #(
  parameter logic [7:0] COM_SYMBOL   = 8'hBC,
  parameter int         LOCK_COUNT   = 4,
  parameter int         LOSS_COUNT   = 4,
  parameter int         COM_INTERVAL = 1024
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       sym_err,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic [2:0] com_count,
  output logic       sync_err,
  output logic [7:0] err_count
);

  localparam logic [2:0]  LOCK_CNT = 3'(LOCK_COUNT);
  localparam logic [3:0]  LOSS_CNT = 4'(LOSS_COUNT);
  localparam logic [15:0] COM_IV   = 16'(COM_INTERVAL);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  com_q, com_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        sync_err_q, sync_err_d;
  logic [7:0]  err_q, err_d;
  logic [3:0]  bad_q, bad_d;
  logic [15:0] gap_q, gap_d;

  logic        good_com;
  logic [3:0]  bad_inc;
  logic [15:0] gap_inc;
  logic        gap_loss;
  logic        run_loss;

  // A sym_err byte is never a COM, even if its bit pattern matches.
  assign good_com = (byte_in == COM_SYMBOL) && !sym_err;
  assign bad_inc  = bad_q + 4'd1;
  assign gap_inc  = gap_q + 16'd1;
  assign gap_loss = (COM_IV != 16'd0) && (gap_inc == COM_IV);
  assign run_loss = sym_err && (bad_inc == LOSS_CNT);

  // Next-state and registered-output logic for hunt/count/locked.
  always_comb begin
    state_d    = state_q;
    com_d      = com_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    sync_err_d = 1'b0;
    err_d      = err_q;
    bad_d      = bad_q;
    gap_d      = gap_q;
    if (byte_valid) begin
      case (state_q)
        ST_HUNT, ST_COUNT: begin
          if (!good_com) begin
            state_d = ST_HUNT;
            com_d   = 3'd0;
          end else if ((state_q == ST_HUNT ? 3'd1 : com_q + 3'd1) == LOCK_CNT) begin
            state_d = ST_LOCKED;
            com_d   = 3'd0;
            bad_d   = 4'd0;
            gap_d   = 16'd0;
          end else begin
            state_d = ST_COUNT;
            com_d   = (state_q == ST_HUNT) ? 3'd1 : com_q + 3'd1;
          end
        end
        ST_LOCKED: begin
          if (good_com) begin
            bad_d = 4'd0;
            gap_d = 16'd0;
          end else begin
            gap_d = gap_inc;
            if (sym_err) begin
              bad_d = bad_inc;
              if (err_q != 8'hFF) err_d = err_q + 8'd1;
            end else begin
              bad_d = 4'd0;
            end
            if (gap_loss || run_loss) begin
              // Losing byte is dropped; hunting resumes on the following byte.
              state_d    = ST_HUNT;
              sync_err_d = 1'b1;
              bad_d      = 4'd0;
              gap_d      = 16'd0;
              com_d      = 3'd0;
            end else if (!sym_err) begin
              data_d  = byte_in;
              valid_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_HUNT;
          com_d   = 3'd0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state_q    <= ST_HUNT;
      com_q      <= 3'd0;
      data_q     <= 8'd0;
      valid_q    <= 1'b0;
      sync_err_q <= 1'b0;
      err_q      <= 8'd0;
      bad_q      <= 4'd0;
      gap_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      com_q      <= com_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sync_err_q <= sync_err_d;
      err_q      <= err_d;
      bad_q      <= bad_d;
      gap_q      <= gap_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign active    = (state_q == ST_LOCKED);
  assign com_count = com_q;
  assign sync_err  = sync_err_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_rx_sync_ctrl.sv
// Bench for rx_sync_ctrl: directed scenarios plus random traffic against a rule-level model.
// Expected status per byte slot and expected forwarded bytes are queued; a monitor compares on negedge.
// No backpressure on the DUT; the bench drives one input slot per clk_4f cycle.
module tb_rx_sync_ctrl;

  localparam int LOCK   = 4;
  localparam int LOSS   = 4;
  localparam int CI     = 8;
  localparam logic [7:0] COM = 8'hBC;

  logic       clk_4f = 1'b0;
  logic       reset  = 1'b1;
  logic [7:0] byte_in = 8'd0;
  logic       byte_valid = 1'b0;
  logic       sym_err = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic [2:0] com_count;
  logic       sync_err;
  logic [7:0] err_count;

  rx_sync_ctrl #(
    .COM_SYMBOL(COM), .LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS), .COM_INTERVAL(CI)
  ) dut (
    .clk_4f(clk_4f), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .sym_err(sym_err), .data_out(data_out), .valid_out(valid_out), .active(active),
    .com_count(com_count), .sync_err(sync_err), .err_count(err_count)
  );

  always #5 clk_4f = ~clk_4f;

  typedef struct packed {
    logic       vld;
    logic       act;
    logic [2:0] cc;
    logic       se;
    logic [7:0] ec;
  } st_t;

  st_t        stq[$];
  logic [7:0] dq[$];
  int n_chk = 0;
  int n_err = 0;

  // Rule-level model of the lane
  bit m_locked;
  int m_run, m_bad, m_gap, m_err;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_run = 0; m_bad = 0; m_gap = 0; m_err = 0;
    stq.delete();
    dq.delete();
  endtask

  task automatic model_step(input logic [7:0] b, input bit v, input bit e);
    st_t s;
    bit gc, lose;
    s = '0;
    if (v) begin
      gc = (b == COM) && !e;
      if (!m_locked) begin
        if (gc) begin
          m_run++;
          if (m_run == LOCK) begin
            m_locked = 1; m_run = 0; m_gap = 0; m_bad = 0;
          end
        end else m_run = 0;
      end else if (gc) begin
        m_bad = 0; m_gap = 0;
      end else begin
        m_gap++;
        if (e) begin
          m_bad++;
          if (m_err < 255) m_err++;
        end else m_bad = 0;
        lose = (m_gap == CI) || (e && m_bad == LOSS);
        if (lose) begin
          m_locked = 0; s.se = 1; m_bad = 0; m_gap = 0; m_run = 0;
        end else if (!e) begin
          s.vld = 1;
          dq.push_back(b);
        end
      end
    end
    s.act = m_locked;
    s.cc  = 3'(m_run);
    s.ec  = 8'(m_err);
    stq.push_back(s);
  endtask

  task automatic send(input logic [7:0] b, input bit v, input bit e);
    byte_in = b; byte_valid = v; sym_err = e;
    @(posedge clk_4f);
    #1;
    model_step(b, v, e);
  endtask

  task automatic lock_up();
    for (int i = 0; i < LOCK; i++) send(COM, 1, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data_out"}, data_out, 0);
    chk({tag, "_valid_out"}, valid_out, 0);
    chk({tag, "_active"}, active, 0);
    chk({tag, "_com_count"}, com_count, 0);
    chk({tag, "_sync_err"}, sync_err, 0);
    chk({tag, "_err_count"}, err_count, 0);
  endtask

  // Monitor: one status slot per clock; forwarded bytes popped whenever valid_out is seen.
  always @(negedge clk_4f) begin
    if (!reset && stq.size() > 0) begin
      st_t e;
      e = stq.pop_front();
      chk("valid_out", valid_out, e.vld);
      chk("active", active, e.act);
      chk("com_count", com_count, e.cc);
      chk("sync_err", sync_err, e.se);
      chk("err_count", err_count, e.ec);
      if (valid_out) begin
        if (dq.size() == 0) chk("data_unexpected", 1, 0);
        else chk("data_out", data_out, dq.pop_front());
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk_4f);
    #1;
    check_reset_outputs("rst0");
    reset = 1'b0;

    // T1: lock then two data bytes
    lock_up();
    send(8'h12, 1, 0);
    send(8'h34, 1, 0);
    send(COM, 1, 0);

    // T2: broken COM run, then a full run
    @(negedge clk_4f); #1; reset = 1'b1; #1; model_reset(); @(negedge clk_4f); #1; reset = 1'b0;
    send(COM, 1, 0); send(COM, 1, 0); send(COM, 1, 0); send(8'h55, 1, 0);
    lock_up();
    send(8'h77, 1, 0);

    // T3: four errors lose lock; three errors then good byte stay locked
    for (int i = 0; i < 4; i++) send(8'h00, 1, 1);
    lock_up();
    for (int i = 0; i < 3; i++) send(8'hBC, 1, 1);
    send(8'h66, 1, 0);
    send(COM, 1, 0);

    // T4: COM interval of 8 expires; then COM after 7 keeps lock
    for (int i = 0; i < 8; i++) send(8'(8'h20 + i), 1, 0);
    lock_up();
    for (int i = 0; i < 7; i++) send(8'(8'h40 + i), 1, 0);
    send(COM, 1, 0);
    send(8'h99, 1, 0);

    // T5: T1 with idle cycles interleaved
    for (int i = 0; i < 4; i++) begin send(COM, 1, 0); send(8'hAA, 0, 0); end
    send(8'h12, 1, 0); send(8'hFF, 0, 1); send(8'h34, 1, 0); send(8'h00, 0, 0);

    // T6a: async reset while locked mid-packet
    send(8'h5A, 1, 0);
    @(negedge clk_4f); #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(posedge clk_4f); @(negedge clk_4f); #1;
    reset = 1'b0;

    // T6b: error count saturation with COMs keeping the lane locked
    lock_up();
    for (int i = 0; i < 90; i++) begin
      for (int j = 0; j < 3; j++) send(8'($urandom), 1, 1);
      send(COM, 1, 0);
    end
    @(negedge clk_4f); #1;
    chk("err_sat", err_count, 255);

    // Random traffic
    @(negedge clk_4f); #1; reset = 1'b1; #1; model_reset(); @(negedge clk_4f); #1; reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [7:0] b;
      bit v, e;
      r = $urandom_range(0, 99);
      b = (r < 45) ? COM : 8'($urandom);
      v = ($urandom_range(0, 9) < 8);
      e = ($urandom_range(0, 99) < 6);
      send(b, v, e);
      if ($urandom_range(0, 199) == 0) lock_up();
    end

    repeat (2) @(posedge clk_4f);
    @(negedge clk_4f); #1;
    chk("status_queue_drained", stq.size(), 0);
    chk("data_queue_drained", dq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
